// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO: sends 8N1 frames back-to-back.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV);

  typedef enum logic {StIdle, StTransmit} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;
  logic            r_full, r_empty, r_overflow;
  logic            w_push, w_pop;

  // Transmit datapath and control
  state_e           r_state, w_state_d;
  logic [9:0]       r_shift, w_shift_d;
  logic [BaudW-1:0] r_baud, w_baud_d;
  logic [3:0]       r_bit, w_bit_d;
  logic             r_done, w_done_d;

  // A push is refused whenever full, even if the FSM pops on the same edge.
  assign w_push = trmt & ~r_full;

  // Occupancy after this edge; full/empty are registered from it.
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  // Capture the byte at the push edge so later tx_data changes are ignored.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= tx_data;
    end
  end

  // FIFO pointers, count, flags and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == CntW'(FIFO_DEPTH));
      r_empty <= (w_count_d == '0);
      if (trmt && r_full) r_overflow <= 1'b1;
    end
  end

  // Next-state logic: load from FIFO head, shift each bit period, chain frames.
  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_done_d  = 1'b0;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!r_empty) begin
          w_pop     = 1'b1;
          w_shift_d = {1'b1, r_mem[r_rptr], 1'b0};
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_state_d = StTransmit;
        end
      end
      StTransmit: begin
        if (r_baud == BaudW'(BAUD_DIV - 1)) begin
          w_baud_d  = '0;
          w_shift_d = {1'b1, r_shift[9:1]};
          w_bit_d   = r_bit + 4'd1;
          // Stop bit period complete
          if (r_bit == 4'd9) begin
            w_done_d = 1'b1;
            w_bit_d  = '0;
            if (!r_empty) begin
              w_pop     = 1'b1;
              w_shift_d = {1'b1, r_mem[r_rptr], 1'b0};
            end else begin
              w_state_d = StIdle;
            end
          end
        end else begin
          w_baud_d = r_baud + BaudW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Transmit state registers; shifter resets to all ones so TX idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_shift <= '1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_done  <= w_done_d;
    end
  end

  assign TX       = r_shift[0];
  assign tx_done  = r_done;
  assign busy     = (r_state == StTransmit);
  assign full     = r_full;
  assign empty    = r_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based frame-timeline model.
module tb_uart_tx_fifo;

  localparam int BD    = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX, tx_done, busy, full, empty, overflow;

  uart_tx_fifo #(
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done),
    .busy    (busy),
    .full    (full),
    .empty   (empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: bytes waiting, the byte on the line and how far into its frame we are.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  logic       m_busy, m_done, m_ovf;
  int         m_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_t    = 0;
    m_cur  = 8'h00;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    logic fin, pop, acc;
    if (rst) begin
      model_reset();
      return;
    end
    fin    = m_busy && (m_t == FRAME - 1);
    m_done = fin;
    pop    = (m_q.size() > 0) && (!m_busy || fin);
    acc    = trmt && (m_q.size() < DEPTH);
    if (trmt && !acc) m_ovf = 1'b1;
    if (pop) begin
      m_cur  = m_q.pop_front();
      m_busy = 1'b1;
      m_t    = 0;
    end else if (m_busy) begin
      if (fin) m_busy = 1'b0;
      else     m_t++;
    end
    if (acc) m_q.push_back(tx_data);
  endtask

  function automatic logic [5:0] model_outs();
    logic etx;
    etx = m_busy ? frame_bit(m_cur, m_t / BD) : 1'b1;
    return {etx, m_busy, m_done, (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf};
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(tag, {26'd0, TX, busy, tx_done, full, empty, overflow}, {26'd0, model_outs()});
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) tick(tag);
  endtask

  task automatic push(input logic [7:0] b, input string tag);
    trmt    = 1'b1;
    tx_data = b;
    tick(tag);
    trmt    = 1'b0;
    tx_data = 8'($urandom);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1;
    check("async_reset", {26'd0, TX, busy, tx_done, full, empty, overflow}, 32'h22);
    idle(3, "reset_hold");
    rst = 1'b0;

    idle(300, "idle");

    push(8'hA5, "single");
    idle(FRAME + 20, "single");

    push(8'h01, "burst3");
    push(8'h02, "burst3");
    push(8'h03, "burst3");
    idle(3 * FRAME + 20, "burst3");

    for (int i = 0; i < 6; i++) push(8'(8'h40 + i), "burst6");
    idle(5 * FRAME + 20, "burst6");

    for (int i = 0; i < 2000; i++) begin
      trmt    = ($urandom_range(0, 11) == 0);
      tx_data = 8'($urandom);
      tick("random");
    end
    trmt = 1'b0;
    idle(6 * FRAME, "drain");

    // Abort a frame during data bit 4 with two bytes still queued.
    push(8'h3C, "abort");
    push(8'hC3, "abort");
    push(8'h5A, "abort");
    idle(5 * BD + 4, "abort");
    check("queued_before_abort", {31'd0, empty}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort_async", {28'd0, TX, busy, tx_done, empty}, 32'b1001);
    idle(2, "abort_hold");
    rst = 1'b0;
    idle(3 * FRAME, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
